dma_path_arbiter: RTL

//  Shares one DMA path controller port between NUM_REQ load/store controllers (one per FPU core).
//  - Round-robin grant; the grant is held for one complete DMA transaction.
//  - Decodes the command header beat to find where the transaction ends, then releases and rotates.
//  - Sits between the per-core load/store controllers and the DMA path controller.

---
 rtl/dma_path_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dma_path_arbiter.sv
// dma_path_arbiter: round-robin share of one DMA path controller port between NUM_REQ load/store controllers
// Ports: clk, rst (sync, active high); per-requester req_i/resp_o, wr_valid_i/wr_data_i/wr_ready_o,
// rd_valid_o/rd_ready_i plus broadcast rd_data_o; downstream dma_req/dma_resp, dma_write_*, dma_read_*;
// status grant_o (owner index), busy_o (not idle), err_o (one-cycle pulse on bad opcode or watchdog release).
// Optional feature: define DMA_ARB_WDT_EN to release a stalled grant after WDT_LIMIT idle cycles.
module dma_path_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int WDT_LIMIT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i,
  output logic [NUM_REQ-1:0]     resp_o,
  input  logic [NUM_REQ-1:0]     wr_valid_i,
  input  logic [NUM_REQ*128-1:0] wr_data_i,
  output logic [NUM_REQ-1:0]     wr_ready_o,
  output logic [NUM_REQ-1:0]     rd_valid_o,
  output logic [127:0]           rd_data_o,
  input  logic [NUM_REQ-1:0]     rd_ready_i,
  output logic                   dma_req,
  input  logic                   dma_resp,
  output logic                   dma_write_valid,
  output logic [127:0]           dma_write_data,
  input  logic                   dma_write_ready,
  input  logic                   dma_read_valid,
  input  logic [127:0]           dma_read_data,
  output logic                   dma_read_ready,
  output logic [IDX_W-1:0]       grant_o,
  output logic                   busy_o,
  output logic                   err_o
);
  typedef enum logic [2:0] {IDLE, REQ, HDR, WDATA, RDATA, REL} state_t;
  state_t state;
  logic [IDX_W-1:0] ptr, off, pick;
  logic [NUM_REQ-1:0] rot, sel;
  logic [15:0] cnt, len, cnt_nx, hdr_len;
  logic [127:0] w_data;
  logic [7:0] hdr_op;
  logic wr_on, rd_on, wr_acc, rd_acc, hdr_bad, wdt_fire;
  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ || WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_param
    $error("dma_path_arbiter: illegal parameter set");
  end
  // requests rotated so that bit 0 is the requester at ptr; the lowest set bit is the winner's offset
  assign rot = NUM_REQ'({req_i, req_i} >> ptr);
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
  end
  assign pick = IDX_W'((int'(ptr) + int'(off)) % NUM_REQ);
  assign sel = NUM_REQ'(1) << grant_o;
  assign wr_on = state == HDR || state == WDATA;
  assign rd_on = state == RDATA;
  assign w_data = wr_data_i[grant_o*128 +: 128];
  assign dma_write_valid = wr_on & wr_valid_i[grant_o];
  assign dma_write_data = wr_on ? w_data : '0;
  assign wr_ready_o = wr_on && dma_write_ready ? sel : '0;
  assign wr_acc = dma_write_valid & dma_write_ready;
  assign rd_valid_o = rd_on && dma_read_valid ? sel : '0;
  assign dma_read_ready = rd_on & rd_ready_i[grant_o];
  assign rd_data_o = rd_on ? dma_read_data : '0;
  assign rd_acc = dma_read_valid & dma_read_ready;
  assign resp_o = state == REQ && dma_resp ? sel : '0;
  assign busy_o = state != IDLE;
  assign hdr_op = w_data[79:72];
  assign hdr_len = w_data[71:56];
  assign hdr_bad = hdr_op != 8'h01 && hdr_op != 8'h03;
  // cnt never exceeds len, so len=16'hFFFF terminates exactly at cnt=16'hFFFF without wrapping
  assign cnt_nx = cnt + 16'd1;
`ifdef DMA_ARB_WDT_EN
  logic [15:0] wdt;
  logic wdt_on, act;
  assign wdt_on = state inside {REQ, HDR, WDATA, RDATA};
  assign act = dma_resp | wr_acc | rd_acc;
  assign wdt_fire = wdt_on && !act && wdt == 16'(WDT_LIMIT - 1);
  always_ff @(posedge clk) wdt <= rst || !wdt_on || act ? '0 : wdt + 16'd1;
`else
  assign wdt_fire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant_o <= '0;
      dma_req <= 1'b0;
      err_o <= 1'b0;
      cnt <= '0;
      len <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: if (|req_i) begin
          grant_o <= pick;
          dma_req <= 1'b1;
          state <= REQ;
        end
        REQ: if (dma_resp) begin
          dma_req <= 1'b0;
          state <= HDR;
        end
        HDR: if (wr_acc) begin
          len <= hdr_len;
          err_o <= hdr_bad;
          state <= hdr_bad || hdr_len == 16'd0 ? REL : hdr_op == 8'h03 ? WDATA : RDATA;
        end
        WDATA: if (wr_acc) begin
          cnt <= cnt_nx;
          state <= cnt_nx == len ? REL : WDATA;
        end
        RDATA: if (rd_acc) begin
          cnt <= cnt_nx;
          state <= cnt_nx == len ? REL : RDATA;
        end
        REL: begin
          ptr <= IDX_W'((int'(grant_o) + 1) % NUM_REQ);
          cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (wdt_fire) begin
        err_o <= 1'b1;
        dma_req <= 1'b0;
        state <= REL;
      end
    end
  end
endmodule
